shared_timer_ctrl: RTL and testbench

Round-robin controller that shares one N-bit up-counter between NREQ requesters needing a timed interval (debounce windows, display dwell, FSM delays). A requester raises `req` with its interval length. The controller grants the counter to one requester, clears and runs it until the programmed terminal count, then pulses `done` to that requester. It sits between the FSM-level clients and the counter datapath and is the only block that drives the counter's clear and enable.

---
 rtl/shared_timer_pkg.sv | 36 +++
 rtl/shared_timer_ctrl_core.sv | 30 +++
 rtl/shared_timer_ctrl.sv | 123 ++++++++++++
 tb/tb_shared_timer_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_timer_pkg.sv
// Shared definitions for shared_timer_ctrl: FSM state encoding and the round-robin pick.
// Optional owner-abort behaviour lives in the top, behind SHARED_TIMER_ABORT_EN.
package shared_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] onehot;
  } pick_t;

  // First set request at or after ptr, wrapping modulo nreq; onehot is zero when nothing is set.
  function automatic pick_t rr_pick(input logic [7:0] req_vec, input logic [2:0] ptr,
                                    input logic [3:0] nreq);
    pick_t      p;
    logic [3:0] k;
    logic       hit;
    p   = '0;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k = {1'b0, ptr} + 4'(i);
      k = (k >= nreq) ? (k - nreq) : k;
      if ((4'(i) < nreq) && !hit && req_vec[k[2:0]]) begin
        hit              = 1'b1;
        p.idx            = k[2:0];
        p.onehot[k[2:0]] = 1'b1;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/shared_timer_ctrl_core.sv
// timer_core: the shared N-bit up-counter datapath with synchronous clear and enable.
// Clear has priority over enable.
module timer_core #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] q
);

  logic [N-1:0] q_r;

  // Counter register: reset, clear on grant, count while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= '0;
    end else if (clr) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= q_r + {{(N-1){1'b0}}, 1'b1};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/shared_timer_ctrl.sv
// Round-robin owner of one shared up-counter; grants, runs to the latched length, pulses done.
// Define SHARED_TIMER_ABORT_EN to abort an interval when its owner drops req during RUN.
module shared_timer_ctrl
  import shared_timer_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] len,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [N-1:0]      q
);

  state_t          state_r, state_s;
  logic [2:0]      ptr_r, ptr_s, owner_r, owner_s, next_ptr_s;
  logic [N-1:0]    len_r, len_s, len_sel_s, q_s;
  logic [NREQ-1:0] grant_r, grant_s, done_r, done_s;
  logic            busy_r;
  logic [7:0]      req_pad_s;
  pick_t           pick_s;
  logic            clr_s, en_s;

  // Widen req to the pick function's fixed width and select the winner's length.
  always_comb begin
    req_pad_s            = '0;
    req_pad_s[NREQ-1:0]  = req;
    pick_s               = rr_pick(req_pad_s, ptr_r, 4'(NREQ));
    len_sel_s            = '0;
    for (int i = 0; i < NREQ; i++) begin
      len_sel_s = (pick_s.idx == 3'(i)) ? len[i*N +: N] : len_sel_s;
    end
    next_ptr_s = (owner_r == 3'(NREQ-1)) ? 3'd0 : (owner_r + 3'd1);
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    len_s   = len_r;
    grant_s = grant_r;
    done_s  = '0;
    clr_s   = 1'b0;
    en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|pick_s.onehot) begin
          state_s = RUN;
          owner_s = pick_s.idx;
          len_s   = len_sel_s;
          grant_s = pick_s.onehot[NREQ-1:0];
          clr_s   = 1'b1;
        end else begin
          grant_s = '0;
        end
      end
      RUN: begin
`ifdef SHARED_TIMER_ABORT_EN
        if (!req_pad_s[owner_r]) begin
          state_s = IDLE;
          grant_s = '0;
          ptr_s   = next_ptr_s;
        end else
`endif
        if (q_s == len_r) begin
          state_s = DONE;
          grant_s = '0;
          done_s  = grant_r;
          ptr_s   = next_ptr_s;
        end else begin
          en_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      owner_r <= 3'd0;
      len_r   <= '0;
      grant_r <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      len_r   <= len_s;
      grant_r <= grant_s;
      done_r  <= done_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  timer_core #(.N(N)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (en_s),
    .q     (q_s)
  );

  assign grant = grant_r;
  assign done  = done_r;
  assign busy  = busy_r;
  assign q     = q_s;

endmodule

// File: tb/tb_shared_timer_ctrl.sv
// Directed self-checking bench for shared_timer_ctrl (N=8, NREQ=4).
// Owner-drop expectations follow SHARED_TIMER_ABORT_EN when it is defined.
module tb_shared_timer_ctrl;

  localparam int N    = 8;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] len;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [N-1:0]      q;

  int checks   = 0;
  int failures = 0;

  shared_timer_ctrl #(.N(N), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .q     (q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_timeout busy=%b expected=0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    len   = '0;
    tick();
    tick();
    checks++;
    if ({grant, done, busy, q} !== {4'b0000, 4'b0000, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_outputs got grant=%b done=%b busy=%b q=%0d expected all zero",
               grant, done, busy, q);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b expected=0001", grant);
    end
    checks++;
    if (q !== 8'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_q got q=%0d busy=%b expected q=0 busy=1", q, busy);
    end
    req = 4'b0000;
    wait_idle("reset");
  endtask

  task automatic test_single();
    req = 4'b0100;
    len[2*N +: N] = 8'd5;
    tick();
    req = 4'b0000;
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if (grant !== 4'b0100 || q !== 8'(c) || done !== 4'b0000) begin
        failures++;
        $display("FAIL single_run c=%0d got grant=%b q=%0d done=%b expected 0100/%0d/0000",
                 c, grant, q, done, c);
      end
      if (c < 5) tick();
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || done !== 4'b0100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_done got grant=%b done=%b busy=%b expected 0000/0100/1",
               grant, done, busy);
    end
    tick();
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0 || q !== 8'd5) begin
      failures++;
      $display("FAIL single_after got done=%b busy=%b q=%0d expected 0000/0/5", done, busy, q);
    end
  endtask

  task automatic test_len_zero();
    req = 4'b0010;
    len[1*N +: N] = 8'd0;
    tick();
    req = 4'b0000;
    checks++;
    if (grant !== 4'b0010 || q !== 8'd0) begin
      failures++;
      $display("FAIL len0_grant got grant=%b q=%0d expected 0010/0", grant, q);
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || done !== 4'b0010) begin
      failures++;
      $display("FAIL len0_done got grant=%b done=%b expected 0000/0010", grant, done);
    end
    tick();
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL len0_after got done=%b busy=%b expected 0000/0", done, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g [5];
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0010;
    exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000;
    exp_g[4] = 4'b0001;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    len = {4{8'd1}};
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (grant !== exp_g[g] || q !== 8'd0) begin
        failures++;
        $display("FAIL rr_grant g=%0d got grant=%b q=%0d expected %b/0", g, grant, q, exp_g[g]);
      end
      if (g == 4) break;
      tick();
      tick();
      checks++;
      if (grant !== 4'b0000 || done !== exp_g[g]) begin
        failures++;
        $display("FAIL rr_done g=%0d got grant=%b done=%b expected 0000/%b",
                 g, grant, done, exp_g[g]);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 4'b0000) begin
        failures++;
        $display("FAIL rr_gap g=%0d got busy=%b done=%b expected 0/0000", g, busy, done);
      end
      tick();
    end
    req = 4'b0000;
    wait_idle("rr");
  endtask

  task automatic test_len_change();
    int pulses;
    pulses = 0;
    req = 4'b0001;
    len[0 +: N] = 8'd3;
    tick();
    req = 4'b0000;
    len[0 +: N] = 8'd9;
    for (int c = 0; c < 8; c++) begin
      if (done !== 4'b0000) pulses++;
      tick();
    end
    checks++;
    if (q !== 8'd3) begin
      failures++;
      $display("FAIL lenchg_q got=%0d expected=3", q);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL lenchg_pulses got=%0d expected=1", pulses);
    end
    wait_idle("lenchg");
  endtask

  task automatic test_owner_drop();
    req = 4'b1001;
    len[3*N +: N] = 8'd6;
    len[0 +: N]   = 8'd0;
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL drop_grant got=%b expected=1000", grant);
    end
    tick();
    tick();
    req = 4'b0001;
`ifdef SHARED_TIMER_ABORT_EN
    tick();
    checks++;
    if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear got grant=%b done=%b busy=%b expected 0000/0000/0",
               grant, done, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || done !== 4'b0000) begin
      failures++;
      $display("FAIL abort_next got grant=%b done=%b expected 0001/0000", grant, done);
    end
`else
    for (int c = 3; c <= 6; c++) begin
      tick();
      checks++;
      if (grant !== 4'b1000 || q !== 8'(c)) begin
        failures++;
        $display("FAIL drop_run c=%0d got grant=%b q=%0d expected 1000/%0d", c, grant, q, c);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || done !== 4'b1000) begin
      failures++;
      $display("FAIL drop_done got grant=%b done=%b expected 0000/1000", grant, done);
    end
    tick();
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL drop_next got grant=%b expected 0001", grant);
    end
`endif
    req = 4'b0000;
    wait_idle("drop");
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    pulses = 0;
    req = 4'b0010;
    len[1*N +: N] = 8'd9;
    tick();
    req = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({grant, done, busy, q} !== {4'b0000, 4'b0000, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL midreset got grant=%b done=%b busy=%b q=%0d expected all zero",
               grant, done, busy, q);
    end
    for (int c = 0; c < 12; c++) begin
      if (done !== 4'b0000) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet got pulses=%0d busy=%b expected 0/0", pulses, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    len   = '0;
    test_reset();
    test_single();
    test_len_zero();
    test_round_robin();
    test_len_change();
    test_owner_drop();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
